exc_flush_ctrl: RTL and testbench

Exception and flush sequencer between the writeback stage and the CSR file. It turns per-instruction exception flags, the pending-interrupt indication and `ertn` into the one-cycle `wb_ex`/`ertn_flush` strobes the CSR file consumes. It then runs a flush/redirect sequence so fetch restarts at the exception entry or at the saved return PC. While the sequence runs, no further writeback event reaches the CSR file.

---
 rtl/exc_pkg.sv | 27 ++
 rtl/exc_prio_enc.sv | 38 +++
 rtl/exc_flush_ctrl.sv | 130 +++++++++++++
 tb/tb_exc_flush_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared definitions for the exception/flush sequencer: exception codes,
// subcodes, counter width and FSM state encoding.
package exc_pkg;

  // Exception codes reported to the CSR file
  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  // Subcodes; every current cause uses subcode 0
  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
  localparam logic [8:0] ESUBCODE_NONE = 9'h000;

  // Flush counter width; holds FLUSH_CYCLES-1 for FLUSH_CYCLES up to 15
  localparam int unsigned FlushCntW = 4;

  // Sequencer states
  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StFlush    = 2'd1,
    StRedirect = 2'd2
  } exc_state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Exception cause priority encoder: folds the per-instruction exception
// flags and the pending interrupt into a single {any, ecode, esubcode}.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic       has_int_i,
  input  logic       adef_i,
  input  logic       ale_i,
  input  logic       ine_i,
  input  logic       sys_i,
  input  logic       brk_i,
  output logic       any_o,
  output logic [5:0] ecode_o,
  output logic [8:0] esubcode_o
);

  // Priority select, highest first: INT, ADEF, INE, SYS, BRK, ALE
  always_comb begin
    any_o      = has_int_i | adef_i | ale_i | ine_i | sys_i | brk_i;
    ecode_o    = 6'h00;
    esubcode_o = ESUBCODE_NONE;
    if (has_int_i) begin
      ecode_o = ECODE_INT;
    end else if (adef_i) begin
      ecode_o    = ECODE_ADEF;
      esubcode_o = ESUBCODE_ADEF;
    end else if (ine_i) begin
      ecode_o = ECODE_INE;
    end else if (sys_i) begin
      ecode_o = ECODE_SYS;
    end else if (brk_i) begin
      ecode_o = ECODE_BRK;
    end else if (ale_i) begin
      ecode_o = ECODE_ALE;
    end
  end

endmodule

// File: rtl/exc_flush_ctrl.sv
// Exception and flush sequencer between writeback and the CSR file.
// Emits one-cycle wb_ex / ertn_flush strobes, then holds pipe_flush for
// FLUSH_CYCLES cycles and offers the latched redirect target to fetch.
// While a sequence is in flight no further writeback event is accepted.
module exc_flush_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2  // legal 1..15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic        wb_adef,
  input  logic        wb_ale,
  input  logic        wb_ine,
  input  logic        wb_sys,
  input  logic        wb_brk,
  input  logic        wb_ertn,
  input  logic        has_int,
  input  logic [31:0] ex_entry,
  input  logic [31:0] era,
  input  logic        redirect_ready,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic        ertn_flush,
  output logic        wb_cancel,
  output logic        pipe_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [FlushCntW-1:0] FlushLoad = FlushCntW'(FLUSH_CYCLES - 1);

  exc_state_e           state_q, state_d;
  logic [FlushCntW-1:0] cnt_q, cnt_d;
  logic [31:0]          pc_q, pc_d;
  logic                 busy_q;

  logic       cause_any;
  logic [5:0] cause_ecode;
  logic [8:0] cause_esubcode;
  logic       trig;
  logic       ex_event;
  logic       ret_event;

  exc_prio_enc u_prio_enc (
    .has_int_i  (has_int),
    .adef_i     (wb_adef),
    .ale_i      (wb_ale),
    .ine_i      (wb_ine),
    .sys_i      (wb_sys),
    .brk_i      (wb_brk),
    .any_o      (cause_any),
    .ecode_o    (cause_ecode),
    .esubcode_o (cause_esubcode)
  );

  // Event decode; resetn gating keeps the strobes low while reset is held
  always_comb begin
    trig      = wb_valid & resetn & (state_q == StIdle);
    ex_event  = trig & cause_any;
    ret_event = trig & wb_ertn & ~cause_any;
  end

  // Next-state, flush counter and redirect target
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle: begin
        if (ex_event) begin
          pc_d    = ex_entry;
          cnt_d   = FlushLoad;
          state_d = StFlush;
        end else if (ret_event) begin
          pc_d    = era;
          cnt_d   = FlushLoad;
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (cnt_q == '0) begin
          state_d = StRedirect;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRedirect: begin
        if (redirect_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counter, target and busy registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pc_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  // Output decode; cause fields read as zero unless an exception commits
  always_comb begin
    wb_ex          = ex_event;
    wb_cancel      = ex_event;
    ertn_flush     = ret_event;
    wb_ecode       = ex_event ? cause_ecode : 6'h00;
    wb_esubcode    = ex_event ? cause_esubcode : 9'h000;
    pipe_flush     = (state_q == StFlush);
    redirect_valid = (state_q == StRedirect);
    redirect_pc    = pc_q;
    busy           = busy_q;
  end

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Self-checking bench for exc_flush_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a cycle-count based model.
module tb_exc_flush_ctrl;

  localparam int unsigned F = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_adef = 1'b0, wb_ale = 1'b0, wb_ine = 1'b0;
  logic        wb_sys = 1'b0, wb_brk = 1'b0, wb_ertn = 1'b0;
  logic        has_int = 1'b0;
  logic [31:0] ex_entry = '0;
  logic [31:0] era = '0;
  logic        redirect_ready = 1'b0;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        ertn_flush, wb_cancel, pipe_flush, redirect_valid, busy;
  logic [31:0] redirect_pc;

  exc_flush_ctrl #(.FLUSH_CYCLES(F)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .wb_valid       (wb_valid),
    .wb_adef        (wb_adef),
    .wb_ale         (wb_ale),
    .wb_ine         (wb_ine),
    .wb_sys         (wb_sys),
    .wb_brk         (wb_brk),
    .wb_ertn        (wb_ertn),
    .has_int        (has_int),
    .ex_entry       (ex_entry),
    .era            (era),
    .redirect_ready (redirect_ready),
    .wb_ex          (wb_ex),
    .wb_ecode       (wb_ecode),
    .wb_esubcode    (wb_esubcode),
    .ertn_flush     (ertn_flush),
    .wb_cancel      (wb_cancel),
    .pipe_flush     (pipe_flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [5:0] ref_ecode(input logic i, input logic adef, input logic ine,
                                           input logic sys, input logic brk, input logic ale);
    if (i)         return 6'h00;
    else if (adef) return 6'h08;
    else if (ine)  return 6'h0D;
    else if (sys)  return 6'h0B;
    else if (brk)  return 6'h0C;
    else if (ale)  return 6'h09;
    else           return 6'h00;
  endfunction

  // Model: a sequence is "active" from the cycle after a strobe; m_k counts
  // cycles since the strobe. Cycles 1..F flush, later cycles offer redirect.
  bit          m_active = 1'b0;
  int          m_k = 0;
  logic [31:0] m_pc = '0;

  always @(posedge clk) begin
    if (!resetn) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_pc     <= '0;
    end else if (!m_active) begin
      if (wb_valid && (has_int | wb_adef | wb_ale | wb_ine | wb_sys | wb_brk)) begin
        m_active <= 1'b1;
        m_k      <= 1;
        m_pc     <= ex_entry;
      end else if (wb_valid && wb_ertn) begin
        m_active <= 1'b1;
        m_k      <= 1;
        m_pc     <= era;
      end
    end else if (m_k > int'(F) && redirect_ready) begin
      m_active <= 1'b0;
    end else begin
      m_k <= m_k + 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic any_c, ex_c, ret_c;
    if (!resetn) begin
      check("rst_wb_ex", wb_ex, 0);
      check("rst_ertn_flush", ertn_flush, 0);
      check("rst_wb_cancel", wb_cancel, 0);
      check("rst_pipe_flush", pipe_flush, 0);
      check("rst_redirect_valid", redirect_valid, 0);
      check("rst_redirect_pc", redirect_pc, 0);
      check("rst_busy", busy, 0);
    end else begin
      any_c = has_int | wb_adef | wb_ale | wb_ine | wb_sys | wb_brk;
      ex_c  = !m_active && wb_valid && any_c;
      ret_c = !m_active && wb_valid && wb_ertn && !any_c;
      check("m_wb_ex", wb_ex, ex_c);
      check("m_wb_cancel", wb_cancel, ex_c);
      check("m_ertn_flush", ertn_flush, ret_c);
      check("m_wb_ecode", wb_ecode,
            ex_c ? ref_ecode(has_int, wb_adef, wb_ine, wb_sys, wb_brk, wb_ale) : 6'h00);
      check("m_wb_esubcode", wb_esubcode, 0);
      check("m_pipe_flush", pipe_flush, m_active && m_k <= int'(F));
      check("m_redirect_valid", redirect_valid, m_active && m_k > int'(F));
      check("m_redirect_pc", redirect_pc, m_pc);
      check("m_busy", busy, m_active);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_in();
    wb_valid = 0; wb_adef = 0; wb_ale = 0; wb_ine = 0;
    wb_sys = 0; wb_brk = 0; wb_ertn = 0; has_int = 0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    redirect_ready = 1'b1;
    while (busy && i < 40) begin
      tick();
      i++;
    end
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int rv, ef;
    repeat (3) tick();
    resetn = 1'b1;

    // SYS exception, FLUSH_CYCLES=2, ready high
    tick();
    wb_valid = 1; wb_sys = 1; ex_entry = 32'h1C008000; redirect_ready = 1;
    sample();
    check("sys_wb_ex", wb_ex, 1);
    check("sys_ecode", wb_ecode, 6'h0B);
    tick(); clear_in();
    sample(); check("sys_flush_t1", pipe_flush, 1);
    tick();
    sample(); check("sys_flush_t2", pipe_flush, 1);
    tick();
    sample();
    check("sys_rv_t3", redirect_valid, 1);
    check("sys_pc_t3", redirect_pc, 32'h1C008000);
    tick();
    sample(); check("sys_busy_t4", busy, 0);

    // ERTN with fetch stalling three redirect cycles
    tick();
    wb_valid = 1; wb_ertn = 1; era = 32'h1C000124; redirect_ready = 0;
    sample();
    check("ertn_flush_t", ertn_flush, 1);
    check("ertn_no_ex", wb_ex, 0);
    rv = 0; ef = 0;
    tick(); clear_in();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      redirect_ready = redirect_valid && (rv == 3);
      sample();
      if (redirect_valid) begin
        rv++;
        check("ertn_pc", redirect_pc, 32'h1C000124);
      end
      if (ertn_flush) ef++;
    end
    check("ertn_rv_cycles", rv, 4);
    check("ertn_extra_pulses", ef, 0);
    check("ertn_idle", busy, 0);

    // Reset while REDIRECT waits on fetch
    tick();
    wb_valid = 1; wb_brk = 1; ex_entry = 32'hDEAD_BEE0; redirect_ready = 0;
    tick(); clear_in();
    tick(); tick();
    sample(); check("rstmid_rv", redirect_valid, 1);
    #2; resetn = 1'b0; #1;
    check("rstmid_rv0", redirect_valid, 0);
    check("rstmid_busy0", busy, 0);
    check("rstmid_pf0", pipe_flush, 0);
    check("rstmid_pc0", redirect_pc, 0);
    tick(); tick();
    resetn = 1'b1; redirect_ready = 1;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("rstmid_no_redirect", redirect_valid, 0);
      check("rstmid_stay_idle", busy, 0);
      tick();
    end

    // Interrupt + ALE + ERTN together
    wb_valid = 1; has_int = 1; wb_ale = 1; wb_ertn = 1; ex_entry = 32'h1C000040;
    sample();
    check("sim_wb_ex", wb_ex, 1);
    check("sim_ecode", wb_ecode, 6'h00);
    check("sim_no_ertn", ertn_flush, 0);
    tick(); clear_in();
    wait_idle();

    // ADEF beats INE; BRK during FLUSH is ignored
    wb_valid = 1; wb_adef = 1; wb_ine = 1; redirect_ready = 0;
    sample();
    check("adef_ecode", wb_ecode, 6'h08);
    check("adef_wb_ex", wb_ex, 1);
    tick(); clear_in();
    wb_valid = 1; wb_brk = 1;
    sample();
    check("flush_brk_no_ex", wb_ex, 0);
    check("flush_brk_pf", pipe_flush, 1);
    tick(); clear_in();
    wait_idle();

    // Interrupt waits for a valid instruction
    clear_in(); has_int = 1;
    for (int i = 0; i < 5; i++) begin
      sample();
      check("int_wait_no_ex", wb_ex, 0);
      tick();
    end
    wb_valid = 1;
    sample();
    check("int_take_ex", wb_ex, 1);
    check("int_take_ecode", wb_ecode, 6'h00);
    tick(); clear_in();
    wait_idle();

    // Randomized traffic with occasional asynchronous reset
    for (int c = 0; c < 2000; c++) begin
      tick();
      resetn         = ($urandom_range(0, 299) != 0);
      wb_valid       = ($urandom_range(0, 1) == 1);
      wb_adef        = ($urandom_range(0, 9) == 0);
      wb_ale         = ($urandom_range(0, 9) == 0);
      wb_ine         = ($urandom_range(0, 9) == 0);
      wb_sys         = ($urandom_range(0, 9) == 0);
      wb_brk         = ($urandom_range(0, 9) == 0);
      wb_ertn        = ($urandom_range(0, 5) == 0);
      has_int        = ($urandom_range(0, 7) == 0);
      redirect_ready = ($urandom_range(0, 1) == 1);
      ex_entry       = $urandom;
      era            = $urandom;
    end
    tick();
    resetn = 1'b1;
    clear_in();
    sample();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
